line_buffer_ctrl: RTL and testbench

Four-line circular buffer controller for the 3x3 image-filter path. Accepts a raster pixel stream one 8-bit pixel per cycle, stores it in four internal line memories, and, whenever three complete lines are held, emits one 72-bit 3x3 window per cycle to the downstream convolution stage. A one-cycle interrupt signals to the upstream DMA that a line slot has been freed.

---
 rtl/line_buffer_ctrl_if.sv | 44 ++++
 rtl/line_buffer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl_if
// Pixel-in / window-out bundle for the 3x3 line buffer controller.
//
// Handshake semantics:
//   Pixel input: a pixel is transferred on a rising edge where
//     i_pix_valid && o_in_ready. The sender may change i_pix_data at any time.
//     A pixel offered while o_in_ready=0 is dropped, not held.
//     o_in_ready comes straight from the occupancy register, so it is stable
//     for the whole cycle.
//   Window output: o_win_valid marks a window on o_win_data for exactly one
//     cycle. There is no ready; the consumer takes every strobe.
//     o_line_intr pulses with the last window of each row.
//
// Signals:
//   i_pix_data   [7:0]   input pixel
//   i_pix_valid          pixel strobe
//   o_in_ready           a free line slot exists
//   o_win_data   [71:0]  3x3 window, top row in MSBs, {left,centre,right} per row
//   o_win_valid          window strobe
//   o_line_intr          row of windows complete, oldest line freed
//
// Modports:
//   master  upstream/downstream side (drives pixels, receives windows)
//   slave   the controller
// -----------------------------------------------------------------------------
interface line_buffer_ctrl_if;
  logic [7:0]  i_pix_data;
  logic        i_pix_valid;
  logic        o_in_ready;
  logic [71:0] o_win_data;
  logic        o_win_valid;
  logic        o_line_intr;

  modport master (
    output i_pix_data, i_pix_valid,
    input  o_in_ready, o_win_data, o_win_valid, o_line_intr
  );

  modport slave (
    input  i_pix_data, i_pix_valid,
    output o_in_ready, o_win_data, o_win_valid, o_line_intr
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
// Four-line circular buffer for a 3x3 filter. Accepts a raster stream of
// 8-bit pixels into four line memories. Whenever three complete lines are
// held, it issues one 72-bit window per cycle for a full row of centres,
// then frees the oldest line and pulses o_line_intr.
//
// Optional feature macro: LBC_ZERO_PAD_EN
//   defined   -> centres 0..LINE_W-1, missing edge pixels read as 0x00
//   undefined -> centres 1..LINE_W-2, no padding
//
// Parameters:
//   LINE_W             pixels per line (4..4096)
// Ports:
//   i_clk              clock, rising edge
//   i_rst              synchronous active-high reset
//   bus                line_buffer_ctrl_if.slave (pixel in, window out)
//   o_dbg_rd_state     read FSM state (0 = IDLE, 1 = RD)
//   o_dbg_lines_full   number of complete, unconsumed lines (0..4)
// -----------------------------------------------------------------------------
module line_buffer_ctrl #(
  parameter int LINE_W = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  line_buffer_ctrl_if.slave  bus,
  output logic               o_dbg_rd_state,
  output logic [2:0]         o_dbg_lines_full
);

  localparam int CW = $clog2(LINE_W);
  localparam logic [CW-1:0] END_COL = CW'(LINE_W - 1);
`ifdef LBC_ZERO_PAD_EN
  localparam logic [CW-1:0] FIRST_C = '0;
  localparam logic [CW-1:0] LAST_C  = CW'(LINE_W - 1);
`else
  localparam logic [CW-1:0] FIRST_C = CW'(1);
  localparam logic [CW-1:0] LAST_C  = CW'(LINE_W - 2);
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_RD = 1'b1} rd_state_t;

  // Line storage; contents are meaningless after reset, so it is not cleared.
  logic [7:0]    mem [4][LINE_W];

  logic [CW-1:0] wr_col;
  logic [1:0]    wr_line;
  logic [CW-1:0] rd_col;
  logic [1:0]    rd_line;
  logic [2:0]    lines_full;
  rd_state_t     state;

  logic          wr_en;
  logic          line_done;
  logic          row_done;

  logic [71:0]   win_data_q;
  logic          win_valid_q;
  logic          line_intr_q;

  assign bus.o_in_ready  = (lines_full != 3'd4);
  assign bus.o_win_data  = win_data_q;
  assign bus.o_win_valid = win_valid_q;
  assign bus.o_line_intr = line_intr_q;
  assign o_dbg_rd_state   = (state == ST_RD);
  assign o_dbg_lines_full = lines_full;

  assign wr_en     = bus.i_pix_valid && bus.o_in_ready;
  assign line_done = wr_en && (wr_col == END_COL);
  assign row_done  = (state == ST_RD) && (rd_col == LAST_C);

  // ---------------------------------------------------------------- write side
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_line][wr_col] <= bus.i_pix_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_col  <= '0;
      wr_line <= '0;
    end else if (wr_en) begin
      if (line_done) begin
        wr_col  <= '0;
        wr_line <= wr_line + 2'd1;
      end else begin
        wr_col  <= wr_col + CW'(1);
      end
    end
  end

  // Occupancy: a line completing on the same edge a row retires cancels out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lines_full <= '0;
    end else begin
      case ({line_done, row_done})
        2'b10:   lines_full <= lines_full + 3'd1;
        2'b01:   lines_full <= lines_full - 3'd1;
        default: lines_full <= lines_full;
      endcase
    end
  end

  // ---------------------------------------------------------------- window tap
  logic [CW-1:0] col_l;
  logic [CW-1:0] col_r;
  logic          pad_l;
  logic          pad_r;
  logic [71:0]   window;

  function automatic logic [23:0] row_tap(input logic [1:0] ln,
                                          input logic [CW-1:0] cl,
                                          input logic [CW-1:0] cc,
                                          input logic [CW-1:0] cr,
                                          input logic zl,
                                          input logic zr);
    row_tap = {zl ? 8'h00 : mem[ln][cl], mem[ln][cc], zr ? 8'h00 : mem[ln][cr]};
  endfunction

  always_comb begin
`ifdef LBC_ZERO_PAD_EN
    // At the edges the neighbour index is held on the centre so it never
    // leaves the array; the tap is then forced to zero.
    pad_l = (rd_col == '0);
    pad_r = (rd_col == END_COL);
    col_l = pad_l ? rd_col : rd_col - CW'(1);
    col_r = pad_r ? rd_col : rd_col + CW'(1);
`else
    pad_l = 1'b0;
    pad_r = 1'b0;
    col_l = rd_col - CW'(1);
    col_r = rd_col + CW'(1);
`endif
    window = {row_tap(rd_line,         col_l, rd_col, col_r, pad_l, pad_r),
              row_tap(rd_line + 2'd1,  col_l, rd_col, col_r, pad_l, pad_r),
              row_tap(rd_line + 2'd2,  col_l, rd_col, col_r, pad_l, pad_r)};
  end

  // ---------------------------------------------------------------- read FSM
  // IDLE always lasts at least one cycle, which is the bubble between rows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rd_col      <= '0;
      rd_line     <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      line_intr_q <= 1'b0;
    end else begin
      win_valid_q <= 1'b0;
      line_intr_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lines_full >= 3'd3) begin
            state  <= ST_RD;
            rd_col <= FIRST_C;
          end
        end
        ST_RD: begin
          win_data_q  <= window;
          win_valid_q <= 1'b1;
          rd_col      <= rd_col + CW'(1);
          if (row_done) begin
            rd_line     <= rd_line + 2'd1;
            line_intr_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_ctrl
// Bench for line_buffer_ctrl with LINE_W=8. A reference model keeps the
// accepted pixel stream as whole lines; each time a line completes and three
// lines are held, it appends that row's windows to the expected queue and
// retires the oldest line. A monitor pops one expected window per o_win_valid.
// Directed steps cover reset values, first-row timing and constants,
// continuous and gappy streaming, and reset in the middle of a row.
// -----------------------------------------------------------------------------
module tb_line_buffer_ctrl;

  localparam int LINE_W = 8;
`ifdef LBC_ZERO_PAD_EN
  localparam int FIRST_C = 0;
  localparam int LAST_C  = LINE_W - 1;
  localparam logic [71:0] FIRST_WIN = 72'h00_00_01_00_10_11_00_20_21;
  localparam logic [71:0] LAST_WIN  = 72'h06_07_00_16_17_00_26_27_00;
`else
  localparam int FIRST_C = 1;
  localparam int LAST_C  = LINE_W - 2;
  localparam logic [71:0] FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;
  localparam logic [71:0] LAST_WIN  = 72'h05_06_07_15_16_17_25_26_27;
`endif
  localparam int WPR = LAST_C - FIRST_C + 1;

  // ------------------------------------------------------- clock and reset
  logic       clk = 1'b0;
  logic       rst;
  logic       dbg_state;
  logic [2:0] dbg_lines_full;

  always #5 clk = ~clk;

  line_buffer_ctrl_if bus ();

  line_buffer_ctrl #(.LINE_W(LINE_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .bus              (bus),
    .o_dbg_rd_state   (dbg_state),
    .o_dbg_lines_full (dbg_lines_full)
  );

  // ------------------------------------------------------- scoreboard state
  int checks = 0;
  int errors = 0;
  logic [71:0]         exp_q[$];
  bit                  exp_last_q[$];
  logic [LINE_W*8-1:0] line_q[$];
  logic [LINE_W*8-1:0] cur_line;
  int cur_col;
  int exp_rows;
  int win_cnt;
  int intr_cnt;
  int ready_low_cnt;
  int intr_snap;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Columns outside the line read as zero, which is exactly the padding rule.
  function automatic logic [7:0] px(input logic [LINE_W*8-1:0] ln, input int c);
    if (c < 0 || c >= LINE_W) return 8'h00;
    return ln[c*8 +: 8];
  endfunction

  task automatic model_accept(input logic [7:0] d);
    logic [71:0] w;
    cur_line[cur_col*8 +: 8] = d;
    cur_col++;
    if (cur_col == LINE_W) begin
      cur_col = 0;
      line_q.push_back(cur_line);
      if (line_q.size() >= 3) begin
        for (int c = FIRST_C; c <= LAST_C; c++) begin
          w = '0;
          for (int r = 0; r < 3; r++)
            w = {w[47:0], px(line_q[r], c - 1), px(line_q[r], c), px(line_q[r], c + 1)};
          exp_q.push_back(w);
          exp_last_q.push_back(c == LAST_C);
        end
        void'(line_q.pop_front());
        exp_rows++;
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_last_q.delete();
    line_q.delete();
    cur_col  = 0;
    cur_line = '0;
    exp_rows = 0;
  endtask

  // ------------------------------------------------------- driver tasks
  task automatic drive(input logic v, input logic [7:0] d);
    logic acc;
    bus.i_pix_valid = v;
    bus.i_pix_data  = d;
    acc = v && (bus.o_in_ready === 1'b1);
`ifdef LBC_ZERO_PAD_EN
    if (v && bus.o_in_ready !== 1'b1) ready_low_cnt++;
`else
    if (v) check("in_ready_stream", bus.o_in_ready, 1);
`endif
    @(negedge clk);
    if (acc) model_accept(d);
  endtask

  task automatic idle(input int n);
    bus.i_pix_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data  = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // ------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (bus.o_win_valid === 1'b1) begin
      win_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL win_unexpected: observed 0x%0h expected no window", bus.o_win_data);
      end else begin
        check("win_data", bus.o_win_data, exp_q.pop_front());
        check("win_intr", bus.o_line_intr, exp_last_q.pop_front());
      end
    end else begin
      check("intr_no_win", bus.o_line_intr, 0);
    end
    if (bus.o_line_intr === 1'b1) begin
      intr_cnt++;
      check("ready_at_intr", bus.o_in_ready, 1);
    end
  end

  // ------------------------------------------------------- directed sequence
  initial begin
    rst = 1'b1;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data  = '0;
    win_cnt = 0;
    intr_cnt = 0;
    ready_low_cnt = 0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_win_valid", bus.o_win_valid, 0);
    check("rst_line_intr", bus.o_line_intr, 0);
    check("rst_win_data", bus.o_win_data, 0);
    check("rst_in_ready", bus.o_in_ready, 1);
    check("rst_lines_full", dbg_lines_full, 0);
    check("rst_state", dbg_state, 0);

    // First row: pixel = row*16 + col
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LINE_W; c++)
        drive(1'b1, 8'(r * 16 + c));
    bus.i_pix_valid = 1'b0;
    check("e0_lines_full", dbg_lines_full, 3);
    check("e0_state", dbg_state, 0);
    @(negedge clk);
    check("e1_state", dbg_state, 1);
    check("e1_win_valid", bus.o_win_valid, 0);
    @(negedge clk);
    check("e2_win_valid", bus.o_win_valid, 1);
    check("first_win", bus.o_win_data, FIRST_WIN);
    check("first_intr", bus.o_line_intr, 0);
    repeat (WPR - 2) @(negedge clk);
    check("penult_intr", bus.o_line_intr, 0);
    @(negedge clk);
    check("last_valid", bus.o_win_valid, 1);
    check("last_win", bus.o_win_data, LAST_WIN);
    check("last_intr", bus.o_line_intr, 1);
    check("row_lines_full", dbg_lines_full, 2);
    @(negedge clk);
    check("bubble_valid", bus.o_win_valid, 0);
    check("bubble_state", dbg_state, 0);

    // Continuous streaming, 6 lines of random data
    do_reset();
    win_cnt = 0;
    intr_cnt = 0;
    for (int i = 0; i < 6 * LINE_W; i++) drive(1'b1, 8'($urandom));
    idle(4 * LINE_W);
    check("stream_intr_vs_model", intr_cnt, exp_rows);
    check("stream_win_cnt", win_cnt, exp_rows * WPR);
`ifndef LBC_ZERO_PAD_EN
    check("stream_intr_cnt", intr_cnt, 4);
`endif
    check("stream_drained", exp_q.size(), 0);

`ifdef LBC_ZERO_PAD_EN
    // Full and drop: offers continue while ready is low; offered values are
    // distinct so a dropped pixel or a duplicate would break the windows.
    do_reset();
    ready_low_cnt = 0;
    for (int i = 0; i < 10 * LINE_W; i++) drive(1'b1, 8'(i));
    idle(4 * LINE_W);
    check("ready_fell", ready_low_cnt > 0, 1);
    check("full_drained", exp_q.size(), 0);
`endif

    // Randomly gapped input
    do_reset();
    for (int i = 0; i < 12 * LINE_W; i++) drive($urandom_range(0, 3) != 0, 8'($urandom));
    idle(4 * LINE_W);
    check("gap_drained", exp_q.size(), 0);

    // Reset in the middle of a row, at its third window
    do_reset();
    for (int i = 0; i < 3 * LINE_W; i++) drive(1'b1, 8'($urandom));
    bus.i_pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_third_valid", bus.o_win_valid, 1);
    intr_snap = intr_cnt;
    do_reset();
    check("abort_win_valid", bus.o_win_valid, 0);
    check("abort_in_ready", bus.o_in_ready, 1);
    check("abort_lines_full", dbg_lines_full, 0);
    check("abort_state", dbg_state, 0);
    idle(2 * LINE_W);
    check("abort_no_intr", intr_cnt, intr_snap);
    for (int i = 0; i < 3 * LINE_W; i++) drive(1'b1, 8'($urandom));
    bus.i_pix_valid = 1'b0;
    @(negedge clk);
    check("restart_e1_valid", bus.o_win_valid, 0);
    @(negedge clk);
    check("restart_e2_valid", bus.o_win_valid, 1);
    idle(2 * LINE_W);
    check("restart_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
